// File: rtl/shift_defs_pkg.sv
// Shared encodings for the EX-stage iterative shifter.
package shift_defs;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SHOP_SLL  = 2'b00,
    SHOP_SRL  = 2'b01,
    SHOP_SRA  = 2'b10,
    SHOP_ROTR = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by k positions according to op.
// Rotate support is present only when SHIFT_ROTR_EN is defined; otherwise ROTR acts as SRL.
module shift_step
  import shift_defs::*;
#(
  parameter int unsigned KW = 4
) (
  input  shop_e             op,
  input  logic [DATA_W-1:0] value,
  input  logic [KW-1:0]     k,
  output logic [DATA_W-1:0] shifted_c
);

`ifdef SHIFT_ROTR_EN
  logic [2*DATA_W-1:0] rot_c;
`endif

  always_comb begin
    shifted_c = value >> k;
`ifdef SHIFT_ROTR_EN
    rot_c = {value, value} >> k;
`endif
    case (op)
      SHOP_SLL: shifted_c = value << k;
      SHOP_SRA: shifted_c = DATA_W'($signed(value) >>> k);
`ifdef SHIFT_ROTR_EN
      SHOP_ROTR: shifted_c = rot_c[DATA_W-1:0];
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_iter_shifter.sv
// Multi-cycle EX-stage shifter: applies up to STEP bit positions per cycle with a busy/done handshake.
// Optional rotate-right for op=11 is enabled by defining SHIFT_ROTR_EN.
module ex_iter_shifter
  import shift_defs::*;
#(
  parameter int unsigned STEP  = 8,
  parameter int unsigned AMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] amt,
  input  logic [DATA_W-1:0] din,
  input  logic              flush,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned KW = $clog2(STEP + 1);

  state_e              state_q, state_d;
  shop_e               op_q, op_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   result_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [AMT_W-1:0]    a_c;
  logic [KW-1:0]       k_c;
  logic [DATA_W-1:0]   step_c;
  logic                accept_c;
  logic                done_d, busy_d, ready_d;
  logic                unused_amt_c;

  assign a_c          = amt[AMT_W-1:0];
  assign unused_amt_c = ^amt[DATA_W-1:AMT_W];

  // Per-cycle step size: the remaining count, capped at STEP.
  always_comb begin
    if (32'(rem_q) > STEP) k_c = KW'(STEP);
    else                   k_c = KW'(rem_q);
  end

  shift_step #(.KW(KW)) u_step (
    .op        (op_q),
    .value     (work_q),
    .k         (k_c),
    .shifted_c (step_c)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result;
    accept_c = 1'b0;

    case (state_q)
      ST_IDLE: accept_c = start;
      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else begin
          work_d = step_c;
          rem_d  = rem_q - AMT_W'(k_c);
          if (rem_q == AMT_W'(k_c)) begin
            state_d  = ST_DONE;
            result_d = step_c;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        accept_c = start && !flush;
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero amount skips SHIFT and publishes din directly.
    if (accept_c) begin
      op_d   = shop_e'(op);
      work_d = din;
      rem_d  = a_c;
      if (a_c == '0) begin
        state_d  = ST_DONE;
        result_d = din;
      end else begin
        state_d  = ST_SHIFT;
      end
    end

    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d == ST_SHIFT);
    ready_d = (state_d != ST_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= SHOP_SLL;
      work_q  <= '0;
      rem_q   <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      result  <= result_d;
      done    <= done_d;
      busy    <= busy_d;
      ready   <= ready_d;
    end
  end

endmodule

// File: tb/tb_ex_iter_shifter.sv
// Self-checking bench for ex_iter_shifter: directed cases plus random ops against an arithmetic model.
// Expected rotate behaviour follows SHIFT_ROTR_EN.
module tb_ex_iter_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] amt;
  logic [31:0] din;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] last_result;

  ex_iter_shifter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .amt    (amt),
    .din    (din),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input logic [31:0] am);
    int unsigned a;
    a = am % 32;
    case (o)
      2'b00: return d << a;
      2'b01: return d >> a;
      2'b10: return 32'($signed(d) >>> a);
      default: begin
`ifdef SHIFT_ROTR_EN
        if (a == 0) return d;
        return (d >> a) | (d << (32 - a));
`else
        return d >> a;
`endif
      end
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [31:0] am);
    int unsigned a;
    a = am % 32;
    if (a == 0) return 1;
    return (a + 7) / 8 + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Starts an op at the current negedge and returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d, input logic [31:0] am);
    int unsigned cyc;
    int unsigned bsy;
    logic [31:0] exp;
    exp   = ref_shift(o, d, am);
    op    = o;
    din   = d;
    amt   = am;
    start = 1'b1;
    cyc   = 0;
    bsy   = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) bsy++;
    end while (!done && cyc < 64);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, cyc, ref_lat(am));
    check({tag, "_busycyc"}, bsy, ref_lat(am) - 1);
    check({tag, "_result"}, result, exp);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    last_result = exp;
  endtask

  initial begin
    int unsigned cyc;
    logic [31:0] exp;
    rst = 1'b1; start = 1'b0; op = 2'b00; amt = '0; din = '0; flush = 1'b0;
    last_result = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_flags", {29'd0, ready, busy, done}, 32'b100);
    rst = 1'b0;
    @(negedge clk);

    run_op("sll20", 2'b00, 32'h0000_0001, 32'd20);
    check("sll20_const", result, 32'h0010_0000);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);

    run_op("sra0", 2'b10, 32'h8000_0000, 32'hFFFF_FFE0);
    check("sra0_const", result, 32'h8000_0000);
    @(negedge clk);
    run_op("sra31", 2'b10, 32'h8000_0000, 32'd31);
    check("sra31_const", result, 32'hFFFF_FFFF);
    @(negedge clk);

    // Back-to-back: second start issued in the done cycle of the first.
    run_op("srl4", 2'b01, 32'hF000_000F, 32'd4);
    check("srl4_const", result, 32'h0F00_0000);
    run_op("b2b_sll8", 2'b00, 32'h0000_00FF, 32'd8);
    check("b2b_const", result, 32'h0000_FF00);
    @(negedge clk);

    // Flush with start on the second SHIFT cycle.
    op = 2'b00; din = 32'h0000_0003; amt = 32'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fl_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("fl_busy2", 32'(busy), 32'd1);
    flush = 1'b1; start = 1'b1; din = 32'h1; amt = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("fl_flags", {29'd0, ready, busy, done}, 32'b100);
    check("fl_result", result, last_result);
    cyc = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) cyc++;
    end
    check("fl_nodone", cyc, 0);

    // Start while busy is ignored.
    exp = ref_shift(2'b01, 32'hDEAD_BEEF, 32'd31);
    op = 2'b01; din = 32'hDEAD_BEEF; amt = 32'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 2'b00; din = 32'h1234_5678; amt = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_lat", cyc, ref_lat(32'd31));
    check("ign_result", result, exp);
    last_result = exp;
    @(negedge clk);

    // Asynchronous reset mid-SHIFT.
    op = 2'b00; din = 32'hFFFF_FFFF; amt = 32'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_result", result, 32'h0);
    check("mrst_flags", {29'd0, ready, busy, done}, 32'b100);
    @(negedge clk);
    rst = 1'b0;
    last_result = '0;
    @(negedge clk);

    run_op("rotr8", 2'b11, 32'h1234_5678, 32'd8);
`ifdef SHIFT_ROTR_EN
    check("rotr8_const", result, 32'h7812_3456);
`else
    check("rotr8_const", result, 32'h0012_3456);
`endif
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(3, 0)), $urandom, $urandom);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
